// File: rtl/fetch.sv
// Instruction fetch stage: PC generation, one-cycle-latency imem requests and a
// small {instr, pc} queue toward decode. Define FETCH_STALL_CNT_EN to add stall_cnt.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_out
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   fifo_instr [FQ_DEPTH];
  logic [31:0]   fifo_pc    [FQ_DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   occ;

  always_comb begin
    valid_out = (count_q != '0);
    instr     = fifo_instr[rd_ptr_q];
    pc_out    = fifo_pc[rd_ptr_q];
    pop       = valid_out && ready_out;
    // A response arriving alongside a redirect belongs to the old path.
    push      = inflight_q && !redirect_valid;
    // Slots already promised: queued entries plus the outstanding response,
    // less the entry leaving this cycle. pop implies count_q >= 1.
    occ       = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_en   = !reset && !redirect_valid && (occ < (CW+1)'(FQ_DEPTH));
    imem_addr = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (imem_en) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      inflight_q <= imem_en;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_instr[wr_ptr_q] <= imem_rdata;
      fifo_pc[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (valid_out && !ready_out) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed, scoreboard-checked bench for fetch: streaming, back-pressure,
// redirects (incl. coincident pop and PC wrap) and the optional stall counter.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] XM  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_out;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int n_xfer = 0;
  logic [31:0] exp_q [$];

  fetch #(.RESET_PC(RPC), .FQ_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr          (instr),
    .pc_out         (pc_out),
    .valid_out      (valid_out),
    .ready_out      (ready_out)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: data one cycle after the request; junk otherwise.
  always @(posedge clk) begin
    if (imem_en === 1'b1) imem_rdata <= imem_addr ^ XM;
    else                  imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock cycle; any transfer to decode is checked against the scoreboard.
  task automatic cyc();
    logic [31:0] e;
    #1;
    if (valid_out === 1'b1 && ready_out === 1'b1) begin
      n_xfer++;
      chk_b("sb_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e);
        chk("instr", instr, e ^ XM);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Reset with a redirect pending, which reset must override.
  task automatic do_reset();
    reset = 1'b1;
    ready_out = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h5555_0000;
    @(posedge clk);
    #1;
    chk_b("rst_valid_out", valid_out, 1'b0);
    chk_b("rst_imem_en", imem_en, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    redirect_valid = 1'b0;
    exp_q.delete();
    #1;
    chk_b("first_req_en", imem_en, 1'b1);
    chk("first_req_addr", imem_addr, RPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ready_out = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    @(posedge clk);
    #1;

    // Streaming from reset: valid from cycle 2, one per cycle.
    do_reset();
    ready_out = 1'b1;
    push_seq(RPC, 40);
    n_xfer = 0;
    for (int c = 0; c < 8; c++) begin
      chk_b("a_valid", valid_out, c >= 2);
      cyc();
    end
    chk("a_xfers", 32'(n_xfer), 32'd6);

    // Back-pressure: four entries fill, fetch stops, head stable, then drain.
    do_reset();
    push_seq(RPC, 40);
    n_xfer = 0;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) chk("b_head_stable", pc_out, exp_q[0]);
      if (c >= 4) chk_b("b_en_off", imem_en, 1'b0);
      cyc();
    end
    chk_b("b_full_valid", valid_out, 1'b1);
    chk("b_full_instr", instr, RPC ^ XM);
    ready_out = 1'b1;
    #1;
    chk_b("b_release_en", imem_en, 1'b1);
    chk("b_release_addr", imem_addr, RPC + 32'h10);
    for (int c = 0; c < 8; c++) begin
      chk_b("b_no_gap", valid_out, 1'b1);
      cyc();
    end
    chk("b_xfers", 32'(n_xfer), 32'd8);

    // Redirect with three queued and one in flight.
    do_reset();
    for (int c = 0; c < 4; c++) cyc();
    chk_b("c_full_en", imem_en, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    #1;
    chk_b("c_redir_en", imem_en, 1'b0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk_b("c_flushed", valid_out, 1'b0);
    chk_b("c_refetch_en", imem_en, 1'b1);
    chk("c_refetch_addr", imem_addr, 32'h0000_2000);
    push_seq(32'h0000_2000, 40);
    ready_out = 1'b1;
    n_xfer = 0;
    for (int c = 0; c < 10; c++) cyc();
    chk("c_xfers", 32'(n_xfer), 32'd8);

    // Redirect coinciding with the pop of 0x104.
    do_reset();
    ready_out = 1'b1;
    push_seq(RPC, 2);
    n_xfer = 0;
    for (int c = 0; c < 3; c++) cyc();
    chk("d_head", pc_out, RPC + 32'h4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    cyc();
    redirect_valid = 1'b0;
    chk("d_xfers_before", 32'(n_xfer), 32'd2);
    chk_b("d_empty", valid_out, 1'b0);
    chk("d_refetch_addr", imem_addr, 32'h0000_3000);
    push_seq(32'h0000_3000, 40);
    n_xfer = 0;
    for (int c = 0; c < 6; c++) cyc();
    chk("d_xfers_after", 32'(n_xfer), 32'd4);

    // Redirect near the top of the address space: PC wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    push_seq(32'hFFFF_FFF8, 4);
    n_xfer = 0;
    for (int c = 0; c < 6; c++) cyc();
    chk("e_xfers", 32'(n_xfer), 32'd4);
    chk("e_sb_left", 32'(exp_q.size()), 32'd0);
    ready_out = 1'b0;

    // Stall counting: seven cycles of valid_out && !ready_out.
    do_reset();
    cyc();
    cyc();
    chk_b("f_valid", valid_out, 1'b1);
    for (int c = 0; c < 7; c++) cyc();
`ifdef FETCH_STALL_CNT_EN
    chk("f_stall_cnt", stall_cnt, 32'd7);
`endif
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 4; fetch-queue entries, power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_en  output  1  instruction-memory read request this cycle.
REQ-006 imem_addr  output  32  word-aligned read address, valid when imem_en=1.
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after the request.
REQ-008 redirect_valid  input  1  branch/flush redirect, single-cycle pulse.
REQ-009 redirect_pc  input  32  new fetch PC, sampled when redirect_valid=1.
REQ-010 instr  output  32  instruction at queue head, to decode.
REQ-011 pc_out  output  32  PC of the instruction on instr.
REQ-012 valid_out  output  1  queue head holds a valid instruction.
REQ-013 ready_out  input  1  decode accepts; transfer occurs when valid_out && ready_out.

Function
REQ-014 fetch SHALL hold a PC register, an in-flight flag with its PC, and an FQ_DEPTH-entry FIFO of {instr, pc}.
REQ-015 imem_en SHALL be 1 iff !reset && !redirect_valid && (count + inflight + (pop?-1:0)) < FQ_DEPTH, where pop = valid_out && ready_out.
REQ-016 imem_addr SHALL equal the PC register; on a request cycle the PC SHALL advance by 4 and the address SHALL be latched as the in-flight PC.
REQ-017 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-018 The cycle after a request, imem_rdata and the in-flight PC SHALL be pushed at the FIFO tail; the push is guaranteed room by REQ-015.
REQ-019 valid_out SHALL equal (count != 0); instr/pc_out SHALL show the head entry combinationally from registered storage.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; pop of the last entry with a push SHALL present the pushed entry on the next cycle.
REQ-021 instr/pc_out SHALL remain stable while valid_out=1 and ready_out=0.
REQ-022 Sustained throughput with ready_out=1 SHALL be one instruction per cycle after a 2-cycle startup (request, push, then valid).
REQ-023 On redirect_valid=1: FIFO SHALL be emptied, any in-flight response discarded (not pushed), PC loaded with redirect_pc, imem_en=0 that cycle; fetching from redirect_pc SHALL begin the next cycle.
REQ-024 A pop coinciding with redirect_valid SHALL still count as a transfer to decode; the FIFO SHALL be empty afterwards.
REQ-025 Pointers SHALL wrap modulo FQ_DEPTH; count SHALL range 0..FQ_DEPTH.

Reset
REQ-026 On reset: PC=RESET_PC, count=0, pointers=0, inflight=0, imem_en=0, valid_out=0.
REQ-027 Reset SHALL take priority over redirect_valid and any pending push or pop.
REQ-028 Reset mid-operation SHALL discard all queued and in-flight instructions; first request after reset is RESET_PC in the cycle reset deasserts.
REQ-029 FIFO data storage need not be reset; instr/pc_out are don't-care while valid_out=0.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: add output stall_cnt (32 bits), reset to 0, incremented (wrapping) each cycle valid_out && !ready_out.
REQ-031 Macro FETCH_STALL_CNT_EN undefined: no stall_cnt port or counter logic; all other behaviour identical.

Verification
REQ-032 Reset RESET_PC=32'h100, ready_out=1, imem returns addr^32'hA5A5_0000 -> valid_out from cycle 2, pc_out 0x100,0x104,0x108... one per cycle, instr matching.
REQ-033 FQ_DEPTH=4, ready_out=0 for 10 cycles -> exactly 4 entries queued, imem_en=0 thereafter, PCs 0x100..0x10C held stable; release -> drained in order, no gaps.
REQ-034 Redirect to 32'h2000 while 3 entries queued and one in flight -> next valid instruction has pc_out=0x2000; no older PC emitted afterwards.
REQ-035 Redirect pulse coinciding with a pop of pc 0x104 -> 0x104 transferred once, FIFO empty next cycle, next pc_out=redirect_pc.
REQ-036 Redirect to 32'hFFFF_FFF8, ready_out=1 -> pc_out sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 With FETCH_STALL_CNT_EN, hold ready_out=0 for 7 cycles with valid_out=1 -> stall_cnt=7; reset -> stall_cnt=0.
